// File: rtl/decoder_scan.sv
// Registered N-to-2^N one-hot decoder with an auto-scan sequencer (direct or scan mode).
// Optional macro DECODER_SCAN_ACTIVE_LOW_EN drives y active-low; idx and wrap are unaffected.
module decoder_scan #(
  parameter int unsigned N    = 2,
  parameter int unsigned DIV  = 4,
  parameter int unsigned LAST = (1 << N) - 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  mode,
  input  logic [N-1:0]          sel,
  output logic [(1 << N)-1:0]   y,
  output logic [N-1:0]          idx,
  output logic                  wrap
);

  localparam int unsigned W  = 1 << N;
  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX  = PW'(DIV - 1);
  localparam logic [N-1:0]  LAST_IDX = N'(LAST);

`ifdef DECODER_SCAN_ACTIVE_LOW_EN
  localparam logic [W-1:0] Y_OFF = '1;
`else
  localparam logic [W-1:0] Y_OFF = '0;
`endif

  logic [PW-1:0] pre;
  logic [N-1:0]  scan_idx;
  logic [PW-1:0] scan_pre;
  logic          scan_wrap;

  // One-hot line pattern in the configured output polarity.
  function automatic logic [W-1:0] line(input logic [N-1:0] i);
    logic [W-1:0] v;
    v = W'(1) << i;
    return v ^ Y_OFF;
  endfunction

  // Next scan position: hold the line until the prescaler expires, then step or wrap.
  always_comb begin
    scan_idx  = idx;
    scan_pre  = pre + PW'(1);
    scan_wrap = 1'b0;
    if (pre == PRE_MAX) begin
      scan_pre = '0;
      if (idx >= LAST_IDX) begin
        scan_idx  = '0;
        scan_wrap = 1'b1;
      end else begin
        scan_idx = idx + N'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y    <= Y_OFF;
      idx  <= '0;
      pre  <= '0;
      wrap <= 1'b0;
    end else if (!en) begin
      y    <= Y_OFF;
      wrap <= 1'b0;
    end else if (!mode) begin
      y    <= line(sel);
      idx  <= sel;
      pre  <= '0;
      wrap <= 1'b0;
    end else begin
      y    <= line(scan_idx);
      idx  <= scan_idx;
      pre  <= scan_pre;
      wrap <= scan_wrap;
    end
  end

endmodule

// File: tb/tb_decoder_scan.sv
// Bench for decoder_scan: three configurations driven together, checked against a per-line timing model.
module tb_decoder_scan;

  logic       clk = 1'b0;
  logic       rst, en, mode;
  logic [1:0] sel;
  logic [2:0] sel3;

  logic [3:0] ya, yb;
  logic [7:0] yc;
  logic [1:0] idxa, idxb;
  logic [2:0] idxc;
  logic       wrapa, wrapb, wrapc;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state per configuration: current line, clocks already spent on it, output enabled, wrap pulse.
  int m_idx  [3];
  int m_cnt  [3];
  int m_on   [3];
  int m_wrap [3];
  int p_div  [3] = '{4, 4, 1};
  int p_last [3] = '{3, 1, 5};
  int p_w    [3] = '{4, 4, 8};

  always #5 clk = ~clk;

  decoder_scan #(.N(2), .DIV(4), .LAST(3)) dut_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel),
    .y(ya), .idx(idxa), .wrap(wrapa));

  decoder_scan #(.N(2), .DIV(4), .LAST(1)) dut_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel),
    .y(yb), .idx(idxb), .wrap(wrapb));

  decoder_scan #(.N(3), .DIV(1), .LAST(5)) dut_c (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel3),
    .y(yc), .idx(idxc), .wrap(wrapc));

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_y(input int k);
    logic [7:0] v;
    logic [7:0] mask;
    mask = 8'((1 << p_w[k]) - 1);
    v = (m_on[k] != 0) ? 8'(1 << m_idx[k]) : 8'h00;
`ifdef DECODER_SCAN_ACTIVE_LOW_EN
    v = ~v & mask;
`endif
    return v & mask;
  endfunction

  // Off pattern for a 4-line output in the configured polarity.
  function automatic logic [7:0] off4();
`ifdef DECODER_SCAN_ACTIVE_LOW_EN
    return 8'h0f;
`else
    return 8'h00;
`endif
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step(input int k, input int s);
    if (rst) begin
      m_idx[k] = 0; m_cnt[k] = 0; m_on[k] = 0; m_wrap[k] = 0;
    end else if (!en) begin
      m_on[k] = 0; m_wrap[k] = 0;
    end else if (!mode) begin
      m_idx[k] = s; m_cnt[k] = 0; m_on[k] = 1; m_wrap[k] = 0;
    end else begin
      m_on[k] = 1;
      m_wrap[k] = 0;
      m_cnt[k] = m_cnt[k] + 1;
      if (m_cnt[k] == p_div[k]) begin
        m_cnt[k] = 0;
        if (m_idx[k] >= p_last[k]) begin
          m_idx[k] = 0;
          m_wrap[k] = 1;
        end else begin
          m_idx[k] = m_idx[k] + 1;
        end
      end
    end
  endtask

  task automatic cycle();
    model_step(0, int'(sel));
    model_step(1, int'(sel));
    model_step(2, int'(sel3));
    @(posedge clk);
    #1;
    check("a.y",    {4'h0, ya},          exp_y(0));
    check("a.idx",  {6'h00, idxa},       8'(m_idx[0]));
    check("a.wrap", {7'h00, wrapa},      8'(m_wrap[0]));
    check("b.y",    {4'h0, yb},          exp_y(1));
    check("b.idx",  {6'h00, idxb},       8'(m_idx[1]));
    check("b.wrap", {7'h00, wrapb},      8'(m_wrap[1]));
    check("c.y",    yc,                  exp_y(2));
    check("c.idx",  {5'h00, idxc},       8'(m_idx[2]));
    check("c.wrap", {7'h00, wrapc},      8'(m_wrap[2]));
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      m_idx[k] = 0; m_cnt[k] = 0; m_on[k] = 0; m_wrap[k] = 0;
    end
    rst = 1'b1; en = 1'b1; mode = 1'b1; sel = 2'd0; sel3 = 3'd0;

    // Reset held for two clocks while scan is requested.
    cycle();
    cycle();
    check("reset.y",    {4'h0, ya},     off4());
    check("reset.idx",  {6'h00, idxa},  8'h00);
    check("reset.wrap", {7'h00, wrapa}, 8'h00);

    // First edge after release shows line 0.
    rst = 1'b0;
    cycle();
`ifdef DECODER_SCAN_ACTIVE_LOW_EN
    check("release.y", {4'h0, ya}, 8'h0e);
`else
    check("release.y", {4'h0, ya}, 8'h01);
`endif

    // Direct decode of every select value.
    mode = 1'b0;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      sel3 = 3'(s + 4);
      cycle();
    end

    // Scan from line 0 through two full cycles.
    sel = 2'd0;
    cycle();
    mode = 1'b1;
    for (int i = 0; i < 34; i++) cycle();

    // Enable gating while line 2 is partway through its count.
    begin
      int guard = 0;
      while (!(m_idx[0] == 2 && m_cnt[0] == 1) && guard < 40) begin
        cycle();
        guard++;
      end
      check("gate.reach", 8'(guard < 40), 8'h01);
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("gate.y",   {4'h0, ya},    off4());
      check("gate.idx", {6'h00, idxa}, 8'h02);
    end
    en = 1'b1;
    for (int i = 0; i < 6; i++) cycle();

    // Reset taken mid-count, then scanning restarts from line 0.
    for (int i = 0; i < 2; i++) cycle();
    rst = 1'b1;
    cycle();
    check("midrst.idx", {6'h00, idxa}, 8'h00);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) cycle();

    // Entry above LAST on the partial-scan instance wraps on the first step.
    mode = 1'b0; sel = 2'd3; sel3 = 3'd7;
    cycle();
    mode = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    check("entry.idx",  {6'h00, idxb},  8'h00);
    check("entry.wrap", {7'h00, wrapb}, 8'h01);
    for (int i = 0; i < 16; i++) cycle();

    // Randomised mix of reset, enable, mode and select.
    for (int i = 0; i < 500; i++) begin
      rst  = ($urandom_range(0, 39) == 0);
      en   = ($urandom_range(0, 7) != 0);
      mode = ($urandom_range(0, 3) != 0);
      sel  = 2'($urandom_range(0, 3));
      sel3 = 3'($urandom_range(0, 7));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
